// File: rtl/chrono_controller.sv
// chrono_controller: front-panel sequencer for the stopwatch.
// Synchronises and debounces the three active-low keys, turns accepted
// presses into single-cycle events and runs the IDLE/RUNNING/STOPPED/RECALL
// mode machine that drives the counter enable, clear, lap capture and recall.
module chrono_controller #(
    parameter  int DEBOUNCE_CYCLES = 500000,
    parameter  int NUM_LAPS        = 3,
    localparam int SLOT_W          = (NUM_LAPS > 1) ? $clog2(NUM_LAPS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                btn_start_n,
    input  logic                btn_lap_n,
    input  logic                btn_clear_n,
    output logic                run,
    output logic                clear_pulse,
    output logic                lap_pulse,
    output logic [SLOT_W-1:0]   lap_slot,
    output logic [NUM_LAPS-1:0] recall_sel,
    output logic [SLOT_W:0]     laps_valid,
    output logic [1:0]          state
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_LAPS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W:0]   LAPS_FULL = (SLOT_W + 1)'(NUM_LAPS);
    localparam logic [SLOT_W:0]   LAPS_ONE  = (SLOT_W + 1)'(1);

    // Button bit order inside the debouncer: [0]=start, [1]=lap, [2]=clear.
    // Internally a set bit means "pressed".
    localparam int BTN_START = 0;
    localparam int BTN_LAP   = 1;
    localparam int BTN_CLEAR = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        STOPPED = 2'd2,
        RECALL  = 2'd3
    } state_t;

    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [2:0]       accepted;
    logic [2:0]       press_ev;
    logic [CNT_W-1:0] db_cnt [3];

    state_t           state_q;
    logic [SLOT_W-1:0] wr_ptr;
    logic [SLOT_W-1:0] recall_idx;

    logic start_ev;
    logic lap_ev;
    logic clear_ev;

    // One-hot decode of a recall slot index.
    function automatic logic [NUM_LAPS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        return NUM_LAPS'(1) << idx;
    endfunction

    // Next recall index, wrapping after the last filled slot.
    function automatic logic [SLOT_W-1:0] next_recall(input logic [SLOT_W-1:0] idx,
                                                      input logic [SLOT_W:0]   count);
        if ({1'b0, idx} == (count - LAPS_ONE)) begin
            return '0;
        end
        return idx + SLOT_ONE;
    endfunction

    // Write pointer advance with wrap at the last slot.
    function automatic logic [SLOT_W-1:0] next_wr_ptr(input logic [SLOT_W-1:0] ptr);
        return (ptr == SLOT_LAST) ? '0 : ptr + SLOT_ONE;
    endfunction

    assign start_ev = press_ev[BTN_START];
    assign lap_ev   = press_ev[BTN_LAP];
    assign clear_ev = press_ev[BTN_CLEAR];
    assign state    = state_q;

    // Two-flop synchronisers, debounce counters and registered press strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            accepted <= '0;
            press_ev <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0  <= ~{btn_clear_n, btn_lap_n, btn_start_n};
            sync_p1  <= sync_p0;
            press_ev <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    // Level stable long enough: accept it; only a press is an event.
                    accepted[i] <= sync_p1[i];
                    db_cnt[i]   <= '0;
                    press_ev[i] <= sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Mode machine with registered outputs; per state the highest-priority
    // legal event (clear > start > lap) acts and the rest are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run         <= 1'b0;
            clear_pulse <= 1'b0;
            lap_pulse   <= 1'b0;
            lap_slot    <= '0;
            recall_sel  <= '0;
            laps_valid  <= '0;
            wr_ptr      <= '0;
            recall_idx  <= '0;
        end else begin
            clear_pulse <= 1'b0;
            lap_pulse   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_ev) begin
                        clear_pulse <= 1'b1;
                    end else if (start_ev) begin
                        state_q <= RUNNING;
                        run     <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (start_ev) begin
                        state_q <= STOPPED;
                        run     <= 1'b0;
                    end else if (lap_ev) begin
                        lap_pulse <= 1'b1;
                        lap_slot  <= wr_ptr;
                        wr_ptr    <= next_wr_ptr(wr_ptr);
                        if (laps_valid != LAPS_FULL) begin
                            laps_valid <= laps_valid + LAPS_ONE;
                        end
                    end
                end
                STOPPED: begin
                    if (clear_ev) begin
                        clear_pulse <= 1'b1;
                        laps_valid  <= '0;
                        wr_ptr      <= '0;
                        state_q     <= IDLE;
                    end else if (start_ev) begin
                        state_q <= RUNNING;
                        run     <= 1'b1;
                    end else if (lap_ev && (laps_valid != '0)) begin
                        state_q    <= RECALL;
                        recall_idx <= '0;
                        recall_sel <= slot_onehot('0);
                    end
                end
                RECALL: begin
                    // Clear only leaves recall here; it never zeroes the counter.
                    if (clear_ev || start_ev) begin
                        state_q    <= STOPPED;
                        recall_sel <= '0;
                    end else if (lap_ev) begin
                        recall_idx <= next_recall(recall_idx, laps_valid);
                        recall_sel <= slot_onehot(next_recall(recall_idx, laps_valid));
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chrono_controller.sv
// tb_chrono_controller: randomized and directed stimulus for chrono_controller,
// compared every cycle against a behavioural model of the front panel.
module tb_chrono_controller;

    localparam int DEB  = 4;
    localparam int LAPS = 3;

    logic       clock;
    logic       reset;
    logic       btn_start_n;
    logic       btn_lap_n;
    logic       btn_clear_n;
    logic       run;
    logic       clear_pulse;
    logic       lap_pulse;
    logic [1:0] lap_slot;
    logic [2:0] recall_sel;
    logic [2:0] laps_valid;
    logic [1:0] state;

    chrono_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_LAPS(LAPS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_start_n(btn_start_n),
        .btn_lap_n(btn_lap_n),
        .btn_clear_n(btn_clear_n),
        .run(run),
        .clear_pulse(clear_pulse),
        .lap_pulse(lap_pulse),
        .lap_slot(lap_slot),
        .recall_sel(recall_sel),
        .laps_valid(laps_valid),
        .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: modes 0..3, accepted key levels, press latency line.
    int       m_mode, m_wptr, m_laps, m_ridx, m_slot;
    bit       m_cp, m_lp;
    bit [2:0] m_acc;
    int       m_runlen [3];
    bit [2:0] m_evq [$];

    // Observation counters and captures.
    int cp_count, lp_count, run_count;
    int got_slot [$];
    int got_valid [$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_wptr = 0; m_laps = 0; m_ridx = 0; m_slot = 0;
        m_cp = 0; m_lp = 0; m_acc = '0;
        for (int i = 0; i < 3; i++) m_runlen[i] = 0;
        m_evq = {3'b000, 3'b000, 3'b000};
    endtask

    // One rising edge of the model: keys accepted after DEB equal samples,
    // the resulting press acts DEB+3 edges after the raw change.
    task automatic model_edge();
        bit [2:0] raw;
        bit [2:0] newev;
        bit [2:0] ev;
        bit st, lp, cl;
        raw   = {~btn_clear_n, ~btn_lap_n, ~btn_start_n};
        newev = '0;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != m_acc[i]) begin
                m_runlen[i]++;
                if (m_runlen[i] == DEB) begin
                    m_acc[i] = raw[i];
                    m_runlen[i] = 0;
                    newev[i] = raw[i];
                end
            end else begin
                m_runlen[i] = 0;
            end
        end
        m_evq.push_back(newev);
        ev = m_evq.pop_front();
        st = ev[0]; lp = ev[1]; cl = ev[2];
        m_cp = 0; m_lp = 0;
        case (m_mode)
            0: begin
                if (cl) m_cp = 1;
                else if (st) m_mode = 1;
            end
            1: begin
                if (st) m_mode = 2;
                else if (lp) begin
                    m_lp = 1;
                    m_slot = m_wptr;
                    m_wptr = (m_wptr + 1) % LAPS;
                    m_laps = (m_laps < LAPS) ? m_laps + 1 : LAPS;
                end
            end
            2: begin
                if (cl) begin
                    m_cp = 1; m_laps = 0; m_wptr = 0; m_mode = 0;
                end else if (st) m_mode = 1;
                else if (lp && m_laps > 0) begin
                    m_mode = 3; m_ridx = 0;
                end
            end
            default: begin
                if (cl || st) m_mode = 2;
                else if (lp) m_ridx = (m_ridx + 1) % m_laps;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk_eq("state", state, m_mode);
        chk_eq("run", run, (m_mode == 1) ? 1 : 0);
        chk_eq("clear_pulse", clear_pulse, m_cp);
        chk_eq("lap_pulse", lap_pulse, m_lp);
        chk_eq("lap_slot", lap_slot, m_slot);
        chk_eq("laps_valid", laps_valid, m_laps);
        chk_eq("recall_sel", recall_sel, (m_mode == 3) ? (1 << m_ridx) : 0);
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_state"}, state, 0);
        chk_eq({tag, "_run"}, run, 0);
        chk_eq({tag, "_clear_pulse"}, clear_pulse, 0);
        chk_eq({tag, "_lap_pulse"}, lap_pulse, 0);
        chk_eq({tag, "_lap_slot"}, lap_slot, 0);
        chk_eq({tag, "_laps_valid"}, laps_valid, 0);
        chk_eq({tag, "_recall_sel"}, recall_sel, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
        cp_count  += int'(clear_pulse);
        lp_count  += int'(lap_pulse);
        run_count += int'(run);
        if (lap_pulse === 1'b1) begin
            got_slot.push_back(int'(lap_slot));
            got_valid.push_back(int'(laps_valid));
        end
    endtask

    task automatic set_keys(input bit [2:0] mask);
        btn_start_n = ~mask[0];
        btn_lap_n   = ~mask[1];
        btn_clear_n = ~mask[2];
    endtask

    task automatic press(input bit [2:0] mask, input int hold, input int gap);
        set_keys(mask);
        repeat (hold) tick();
        set_keys(3'b000);
        repeat (gap) tick();
    endtask

    int exp_slots [4] = '{0, 1, 2, 0};
    int exp_valid [4] = '{1, 2, 3, 3};
    int exp_sel   [3] = '{1, 2, 1};

    initial begin
        reset = 1'b0;
        set_keys(3'b000);
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        reset = 1'b1;

        // Start press held 20 cycles: reaction exactly DEB+3 edges later.
        set_keys(3'b001);
        repeat (6) tick();
        chk_eq("start_lat6_run", run, 0);
        tick();
        chk_eq("start_lat7_run", run, 1);
        chk_eq("start_lat7_state", state, 1);
        repeat (13) tick();
        set_keys(3'b000);
        repeat (10) tick();
        chk_eq("release_no_event", state, 1);

        // Short lap glitch while running.
        press(3'b010, 3, 10);
        chk_eq("glitch_laps", laps_valid, 0);

        // Four laps: slots 0,1,2,0 and saturating count.
        got_slot.delete();
        got_valid.delete();
        repeat (4) press(3'b010, 8, 8);
        chk_eq("lap_count", got_slot.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk_eq("lap_slot_seq", (got_slot.size() > k) ? got_slot[k] : 99, exp_slots[k]);
            chk_eq("lap_valid_seq", (got_valid.size() > k) ? got_valid[k] : 99, exp_valid[k]);
        end

        // Stop, clear, run two laps, stop.
        press(3'b001, 8, 8);
        press(3'b100, 8, 8);
        press(3'b001, 8, 8);
        press(3'b010, 8, 8);
        press(3'b010, 8, 8);
        press(3'b001, 8, 8);
        chk_eq("pre_recall_laps", laps_valid, 2);
        chk_eq("pre_recall_state", state, 2);

        // Recall cycles through the two filled slots.
        for (int k = 0; k < 3; k++) begin
            press(3'b010, 8, 8);
            chk_eq("recall_sel_seq", recall_sel, exp_sel[k]);
            chk_eq("recall_state", state, 3);
        end
        press(3'b001, 8, 8);
        chk_eq("recall_exit_state", state, 2);
        chk_eq("recall_exit_sel", recall_sel, 0);

        // Clear and start together in STOPPED: clear wins.
        cp_count = 0;
        run_count = 0;
        press(3'b101, 8, 8);
        chk_eq("simul_clear_pulses", cp_count, 1);
        chk_eq("simul_state", state, 0);
        chk_eq("simul_laps", laps_valid, 0);
        chk_eq("simul_run_cycles", run_count, 0);

        // Reset in the middle of a run with two laps stored.
        press(3'b001, 8, 8);
        press(3'b010, 8, 8);
        press(3'b010, 8, 8);
        chk_eq("prereset_laps", laps_valid, 2);
        chk_eq("prereset_run", run, 1);
        #1 reset = 1'b0;
        #1 check_zero("midreset");
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        cp_count = 0;
        lp_count = 0;
        repeat (20) tick();
        chk_eq("post_reset_state", state, 0);
        chk_eq("post_reset_clear_pulses", cp_count, 0);
        chk_eq("post_reset_lap_pulses", lp_count, 0);

        // Random key activity, including glitches and simultaneous presses.
        for (int n = 0; n < 150; n++) begin
            bit [2:0] mask;
            mask = 3'($urandom_range(0, 7));
            press(mask, $urandom_range(1, 10), $urandom_range(1, 10));
        end
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chrono_controller.md
Name: chrono_controller

Overview:
Front-panel sequencer for the stopwatch datapath. It synchronises and debounces three raw active-low pushbuttons (start/stop, lap, clear) and runs a mode FSM. From that FSM it drives the counter's run enable, a clear pulse, lap-capture pulses with a rotating slot index, and a one-hot lap-recall select. It sits between the board KEY pins and the chronometer counter/lap-storage block.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required before a button level is accepted (10 ms at 50 MHz)
NUM_LAPS, 3, number of lap storage slots; SLOT_W = $clog2(NUM_LAPS) is derived, not overridable

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; clears all state and outputs
btn_start_n  in  1  raw start/stop button, active-low, asynchronous to clock
btn_lap_n  in  1  raw lap/recall button, active-low, asynchronous
btn_clear_n  in  1  raw clear button, active-low, asynchronous
run  out  1  counter enable, high only in RUNNING
clear_pulse  out  1  one-cycle pulse: zero the counter
lap_pulse  out  1  one-cycle pulse: capture current time into slot lap_slot
lap_slot  out  SLOT_W  slot written on lap_pulse; valid in the cycle lap_pulse is high
recall_sel  out  NUM_LAPS  one-hot slot to display in RECALL, all-zero otherwise
laps_valid  out  SLOT_W+1  number of filled slots, saturates at NUM_LAPS
state  out  2  IDLE=0, RUNNING=1, STOPPED=2, RECALL=3

Behaviour:
- Reset (reset low, async): state=IDLE, run=0, clear_pulse=0, lap_pulse=0, lap_slot=0, recall_sel=0, laps_valid=0, all debouncers released (not pressed), counters zeroed. Reset asserted mid-operation aborts everything immediately; no pulse is emitted on release.
- Per button: a 2-flop synchroniser feeds a debouncer. The debounce counter increments while the synchronised level differs from the accepted level and clears when they match. When it reaches DEBOUNCE_CYCLES, the accepted level flips and the counter clears. A press event is a one-cycle internal strobe on accepted not-pressed -> pressed. Release generates no event. Holding a button gives exactly one event.
- Latency: a raw level held stable produces the FSM reaction (state change or pulse) DEBOUNCE_CYCLES+3 rising edges after the change. Glitches shorter than DEBOUNCE_CYCLES samples produce nothing.
- Simultaneous events in the same cycle: priority clear > start > lap. Only the highest-priority event that is legal in the current state acts; the others are discarded.
- IDLE: start -> RUNNING. clear -> clear_pulse, stay IDLE. lap ignored.
- RUNNING: start -> STOPPED. lap -> lap_pulse with lap_slot=write pointer; pointer advances and wraps NUM_LAPS-1 -> 0; laps_valid increments, saturating at NUM_LAPS. clear ignored.
- STOPPED: start -> RUNNING. clear -> clear_pulse, laps_valid=0, write pointer=0, -> IDLE. lap -> RECALL with recall index 0 if laps_valid>0; ignored if laps_valid=0.
- RECALL: lap -> recall index+1, wrapping to 0 after laps_valid-1. start -> STOPPED. clear -> STOPPED (exit only, no clear_pulse). run stays 0 throughout.
- recall_sel = one-hot(recall index) in RECALL only; it is registered and changes in the same cycle as state.
- All outputs are registered. clear_pulse and lap_pulse are never high for two consecutive cycles.

Test Plan:
- DEBOUNCE_CYCLES=4: reset, press start held 20 cycles -> run=1 and state=1 exactly 7 edges after the raw press; release emits no event.
- 3-cycle glitch on btn_lap_n while RUNNING -> no lap_pulse, laps_valid stays 0.
- RUNNING, 4 lap presses -> lap_pulse x4 with lap_slot 0,1,2,0; laps_valid 1,2,3,3.
- STOPPED with laps_valid=2, lap x3 -> recall_sel 001,010,001; then start -> state=2, recall_sel=000.
- STOPPED, clear and start pressed in the same cycle -> clear_pulse once, state=0, laps_valid=0, run stays 0.
- RUNNING with laps_valid=2, assert reset mid-run -> all outputs 0 at once; after release, state=0 and no pulses.
